// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter via a ld_tx_data/tx_empty load handshake.
// A byte is popped only once the transmitter acknowledges the load by dropping tx_empty.
module uart_tx_feeder #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_overflow,
    input  logic              tx_empty,
    output logic              ld_tx_data,
    output logic [7:0]        tx_data,
    output logic              wr_full,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              busy
);

    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        push       = wr_en && !wr_full;
        pop        = (state == LOAD) && !tx_empty;
        count_next = fifo_count;
        if (push && !pop)
            count_next = fifo_count + 1'b1;
        else if (pop && !push)
            count_next = fifo_count - 1'b1;
    end

    // NOTE: the storage array is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: state is updated only with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wr_full    <= 1'b0;
            overflow   <= 1'b0;
            ld_tx_data <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            wr_full    <= (count_next == FULL_COUNT);

            // A dropped write beats a simultaneous clear.
            if (wr_en && wr_full)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;

            case (state)
                IDLE: begin
                    ld_tx_data <= 1'b0;
                    if (fifo_count != '0 && tx_empty) begin
                        tx_data    <= mem[rd_ptr];
                        ld_tx_data <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // Hold the request until the transmitter shows it took the byte.
                    if (!tx_empty) begin
                        ld_tx_data <= 1'b0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tx_empty)
                        state <= IDLE;
                end
                default: begin
                    ld_tx_data <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign busy = (fifo_count != '0) || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: directed scenarios plus random traffic,
// checked against a queue model and a simple transmitter responder.
module tb_uart_tx_feeder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              clr_overflow;
    logic              tx_empty;
    logic              ld_tx_data;
    logic [7:0]        tx_data;
    logic              wr_full;
    logic [ADDR_W:0]   fifo_count;
    logic              overflow;
    logic              busy;

    uart_tx_feeder #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .tx_empty     (tx_empty),
        .ld_tx_data   (ld_tx_data),
        .tx_data      (tx_data),
        .wr_full      (wr_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #12.5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queued bytes, sticky overflow, transmitter responder state.
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         te;
    bit         auto_tx;
    int         tx_wait;
    int         tx_busy;
    int         tx_hold;
    int         sent_cnt;
    int         acc_cnt;
    logic [7:0] last_sent;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: run the transmitter responder, update the model, drive, then check.
    task automatic tick(input bit wr, input logic [7:0] d, input bit clr);
        bit pop_now;
        bit was_full;
        bit accept;
        was_full = (exp_q.size() == DEPTH);
        if (auto_tx) begin
            if (te) begin
                if (ld_tx_data) begin
                    if (tx_wait == 0) te = 1'b0;
                    else tx_wait--;
                end
            end else begin
                if (tx_busy == 0) begin
                    te      = 1'b1;
                    tx_wait = $urandom_range(0, 3);
                end else begin
                    tx_busy--;
                end
            end
        end
        pop_now = !te && ld_tx_data;
        if (pop_now) begin
            check("queue_nonempty_on_load", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("tx_order", tx_data, exp_q[0]);
                last_sent = exp_q.pop_front();
                sent_cnt++;
                tx_busy = tx_hold;
            end
        end
        accept = wr && !was_full;
        if (accept) begin
            exp_q.push_back(d);
            acc_cnt++;
        end
        if (wr && !accept) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;

        wr_en        = wr;
        wr_data      = d;
        clr_overflow = clr;
        tx_empty     = te;
        @(negedge clk);
        wr_en        = 1'b0;
        clr_overflow = 1'b0;

        check("fifo_count", fifo_count, exp_q.size());
        check("overflow", overflow, m_ovf);
        check("wr_full", wr_full, 32'(exp_q.size() == DEPTH));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        auto_tx = 1'b1;
        while ((exp_q.size() != 0 || busy || !te) && n < 3000) begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    initial begin
        logic [7:0] hold;
        int         stall_bad;

        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
        te = 1'b1; tx_empty = 1'b1; auto_tx = 1'b0;
        tx_wait = 0; tx_busy = 0; tx_hold = 10; sent_cnt = 0; acc_cnt = 0; m_ovf = 1'b0;
        last_sent = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ld", ld_tx_data, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_wr_full", wr_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Single byte with manual transmitter.
        tick(1'b1, 8'hA5, 1'b0);
        check("single_ld_not_early", ld_tx_data, 0);
        tick(1'b0, 8'h00, 1'b0);
        check("single_ld", ld_tx_data, 1);
        check("single_data", tx_data, 8'hA5);
        repeat (20) tick(1'b0, 8'h00, 1'b0);
        check("single_ld_held", ld_tx_data, 1);
        te = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        check("single_ld_drop", ld_tx_data, 0);
        check("single_busy_drain", busy, 1);
        te = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("single_busy_done", busy, 0);

        // Burst 0x01..0x05 with a 10-cycle transmitter.
        sent_cnt = 0; auto_tx = 1'b1; tx_hold = 10; tx_wait = 0;
        for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0);
        drain("burst");
        check("burst_count", sent_cnt, 5);
        check("burst_last", last_sent, 8'h05);

        // Fill past full with the transmitter busy.
        auto_tx = 1'b0; te = 1'b0;
        for (int i = 0; i <= 16; i++) tick(1'b1, 8'(i), 1'b0);
        check("ovf_full", wr_full, 1);
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        tick(1'b0, 8'h00, 1'b1);
        check("ovf_cleared", overflow, 0);
        sent_cnt = 0; te = 1'b1; tx_wait = 0;
        drain("ovf");
        check("ovf_sent", sent_cnt, 16);
        check("ovf_last", last_sent, 8'h0F);

        // Write coinciding with the pop.
        auto_tx = 1'b0; te = 1'b1; sent_cnt = 0;
        tick(1'b1, 8'h31, 1'b0);
        tick(1'b1, 8'h32, 1'b0);
        tick(1'b1, 8'h33, 1'b0);
        check("simul_ld", ld_tx_data, 1);
        check("simul_pre_count", fifo_count, 3);
        te = 1'b0;
        tick(1'b1, 8'hEE, 1'b0);
        check("simul_count", fifo_count, 3);
        tx_busy = 2;
        drain("simul");
        check("simul_sent", sent_cnt, 4);
        check("simul_last", last_sent, 8'hEE);

        // Transmitter never acknowledges.
        auto_tx = 1'b0; te = 1'b1;
        tick(1'b1, 8'h5A, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        hold = tx_data;
        stall_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (ld_tx_data !== 1'b1 || tx_data !== hold) stall_bad++;
        end
        check("stall_stable", stall_bad, 0);
        check("stall_data", tx_data, 8'h5A);
        check("stall_count", fifo_count, 1);
        te = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        tx_busy = 1;
        drain("stall");

        // Reset while loading with four bytes queued.
        auto_tx = 1'b0; te = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0);
        check("mid_ld", ld_tx_data, 1);
        check("mid_count", fifo_count, 4);
        do_reset();
        check("mid_rst_ld", ld_tx_data, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_full", wr_full, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_busy", busy, 0);

        // Random traffic against the model.
        sent_cnt = 0; acc_cnt = 0; auto_tx = 1'b1; te = 1'b1; tx_wait = 0;
        for (int i = 0; i < 600; i++) begin
            tx_hold = $urandom_range(8, 12);
            tick($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 30) == 0);
        end
        drain("rand");
        check("rand_sent", sent_cnt, acc_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
